decodificador_scan: RTL and testbench
=====================================

# decodificador_scan

Parametrised, registered successor to the team's 2-to-4 active-low decoder. It drives 2^SEL_W active-low channel outputs from a direct select input (mode 0) or from an internal round-robin scanner with programmable dwell (mode 1). It keeps the sensor-inhibit rule: channel 0 is the home channel and is never inhibited. A one-cycle break-before-make dead time is inserted on every channel change. It sits between the control FSM and the actuator/indicator drivers.

## Interface
- SEL_W, 2, select width; number of channels N = 2^SEL_W (SEL_W ≥ 1)
- SENS_W, 3, sensor vector width
- DWELL, 4, clock cycles per channel in scan mode (DWELL ≥ 2)
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  block enable; 0 forces all outputs inactive
- mode  input  1  0 = direct select, 1 = scan
- sel  input  SEL_W  channel select in mode 0, ignored in mode 1
- sens  input  SENS_W  sensor vector; all-zero means inhibit
- out_n  output  N  active-low one-cold channel outputs, registered
- active_idx  output  SEL_W  index of the channel currently held (cur_idx)
- valid  output  1  high when state is DRIVE and some out_n bit is 0

## Operation
- Target index: tgt = sel when mode = 0, else scan_idx.
- inhibit = (sens == 0). In decode(k, inhibit), bit k is 0 when k = 0 or inhibit = 0. All other bits are 1.
- Scanner (scan_idx, dwell_cnt):
  - When en = 0 or mode = 0, both load 0.
  - Otherwise dwell_cnt increments each cycle. At DWELL−1 it wraps to 0 and scan_idx increments, wrapping from N−1 to 0.
  - dwell_cnt width is clog2(DWELL).
- FSM states are OFF, DRIVE and BLANK. All transitions and register updates happen on the clock edge.
  - OFF:
    - out_n ← all 1.
    - If en = 1, go to DRIVE, with cur_idx ← tgt and out_n ← decode(tgt, inhibit).
  - DRIVE:
    - If en = 0, go to OFF with out_n ← all 1.
    - Else if tgt ≠ cur_idx, go to BLANK with out_n ← all 1.
    - Else stay in DRIVE with out_n ← decode(cur_idx, inhibit). This re-evaluates inhibit every cycle.
  - BLANK:
    - If en = 0, go to OFF.
    - Else go to DRIVE, with cur_idx ← tgt (re-sampled) and out_n ← decode(tgt, inhibit).
- en has priority over every other condition.
- A mode switch is just a tgt change and follows the same rules.
- An inhibit change never causes BLANK. It only gates the outputs.
- At most one out_n bit is 0 in any cycle.

## Timing
- Reset values: state OFF, out_n all 1, active_idx 0, valid 0, scan_idx 0, dwell_cnt 0.
- Reset mid-operation: all outputs return to reset values on the edge that samples rst_n = 0, overriding all other inputs.
- Enable latency: en sampled high in OFF at edge k → out_n valid after edge k.
- Disable latency: en sampled low → out_n all 1 after the same edge.
- Direct-mode channel change: sel changes before edge k → all 1 after edge k (BLANK) → new channel after edge k+1. The dead time is exactly 1 cycle.
- If sel returns to cur_idx during BLANK, BLANK still completes and the same channel is reloaded.
- Inhibit latency: sens change sampled at edge k → out_n updated after edge k.
- Scan steady state, per channel period of DWELL cycles: 1 BLANK cycle, then DWELL−1 DRIVE cycles.
- Scan is entered from reset or from mode 0 with scan_idx = 0. The first channel-0 period has no BLANK if the FSM enters from OFF.
- Scan wrap: N−1 → 0, with a BLANK in between.
- valid is registered with out_n and has identical latency.

## Test plan
- Reset/enable (SEL_W=2):
  - Stimulus: hold rst_n=0 for 3 cycles with en=1, then release rst_n with mode=0, sel=2, sens=3'b001.
  - Required: out_n=4'b1111 throughout reset, then out_n=4'b1011, active_idx=2, valid=1 one edge after release.
- Inhibit:
  - Stimulus: sel=2, then sens=0.
  - Required: out_n=4'b1111 and valid=0 next edge, active_idx stays 2.
  - Stimulus: then sel=0.
  - Required: one BLANK cycle, then out_n=4'b1110 despite inhibit.
- Dead time:
  - Stimulus: with sens≠0, sel steps 1→3.
  - Required: out_n sequence 1101, 1111, 0111 on consecutive edges.
- Scan:
  - Stimulus: mode=1, DWELL=4, sens≠0, run for 20 cycles.
  - Required: the channel order is 0,1,2,3,0; each channel after the first has 1 all-high cycle followed by 3 driven cycles; no cycle ever has two bits low.
- Disable mid-BLANK:
  - Stimulus: drop en during the BLANK cycle.
  - Required: state OFF, out_n=4'b1111, valid=0.
  - Stimulus: raise en with mode=1.
  - Required: channel 0 is driven after one edge, since the scanner was cleared.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 while channel 2 is driven.
  - Required: all outputs at reset values on the next edge; after release, scan restarts at channel 0.

Source files
------------

// File: rtl/decodificador_scan.sv
// Registered active-low channel decoder with direct-select and round-robin scan modes.
// Channel 0 is the home channel and ignores sensor inhibit; every channel change passes through a one-cycle blank.
module decodificador_scan #(
    parameter int SEL_W  = 2,
    parameter int SENS_W = 3,
    parameter int DWELL  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [SENS_W-1:0]       sens,
    output logic [(1<<SEL_W)-1:0]   out_n,
    output logic [SEL_W-1:0]        active_idx,
    output logic                    valid
);

    localparam int N    = 1 << SEL_W;
    localparam int DW_W = $clog2(DWELL);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [SEL_W-1:0] IDX_ONE = 1;
    localparam logic [DW_W-1:0]  DW_ONE  = 1;
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
    logic [N-1:0]     out_n_q, out_n_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;

    logic [SEL_W-1:0] tgt;
    logic             inhibit;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] k, input logic inh);
        logic [N-1:0] v;
        v = '1;
        if (k == '0 || !inh)
            v[k] = 1'b0;
        return v;
    endfunction

    assign tgt     = mode ? scan_idx_q : sel;
    assign inhibit = (sens == '0);

    always_comb begin
        scan_idx_d  = scan_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        if (!en || !mode) begin
            scan_idx_d  = '0;
            dwell_cnt_d = '0;
        end else if (dwell_cnt_q == DW_LAST) begin
            dwell_cnt_d = '0;
            scan_idx_d  = scan_idx_q + IDX_ONE;
        end else begin
            dwell_cnt_d = dwell_cnt_q + DW_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        out_n_d   = '1;
        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d   = ST_DRIVE;
                    cur_idx_d = tgt;
                    out_n_d   = decode(tgt, inhibit);
                end
            end
            ST_DRIVE: begin
                if (!en)
                    state_d = ST_OFF;
                else if (tgt != cur_idx_q)
                    state_d = ST_BLANK;
                else
                    out_n_d = decode(cur_idx_q, inhibit);
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_OFF;
                end else begin
                    state_d   = ST_DRIVE;
                    cur_idx_d = tgt;
                    out_n_d   = decode(tgt, inhibit);
                end
            end
            default: state_d = ST_OFF;
        endcase
        // valid is derived from next-state values so it lands on the same edge as out_n
        valid_d = (state_d == ST_DRIVE) && (out_n_d != '1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            cur_idx_q   <= '0;
            out_n_q     <= '1;
            valid_q     <= 1'b0;
            scan_idx_q  <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            out_n_q     <= out_n_d;
            valid_q     <= valid_d;
            scan_idx_q  <= scan_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign out_n      = out_n_q;
    assign active_idx = cur_idx_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_decodificador_scan.sv
// Directed bench for decodificador_scan with SEL_W=2, SENS_W=3, DWELL=4.
module tb_decodificador_scan;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [2:0] sens;
    logic [3:0] out_n;
    logic [1:0] active_idx;
    logic       valid;

    int n_cmp;
    int n_bad;

    decodificador_scan #(.SEL_W(2), .SENS_W(3), .DWELL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sel        (sel),
        .sens       (sens),
        .out_n      (out_n),
        .active_idx (active_idx),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd2; sens = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({out_n, active_idx, valid} !== {4'b1111, 2'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got out_n=%b idx=%0d valid=%b, exp out_n=1111 idx=0 valid=0",
                         i, out_n, active_idx, valid);
            end
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1011, 2'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_release: got out_n=%b idx=%0d valid=%b, exp out_n=1011 idx=2 valid=1",
                     out_n, active_idx, valid);
        end
    endtask

    task automatic test_inhibit();
        sens = 3'b000;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1111, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL inhibit_gate: got out_n=%b idx=%0d valid=%b, exp out_n=1111 idx=2 valid=0",
                     out_n, active_idx, valid);
        end
        sel = 2'd0;
        step();
        n_cmp++;
        if ({out_n, valid} !== {4'b1111, 1'b0}) begin
            n_bad++;
            $display("FAIL inhibit_blank: got out_n=%b valid=%b, exp out_n=1111 valid=0", out_n, valid);
        end
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1110, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL inhibit_home: got out_n=%b idx=%0d valid=%b, exp out_n=1110 idx=0 valid=1",
                     out_n, active_idx, valid);
        end
    endtask

    task automatic test_dead_time();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1111; exp_seq[2] = 4'b0111;
        sens = 3'b101;
        sel  = 2'd1;
        step();  // blank leaving channel 0
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) sel = 2'd3;
            n_cmp++;
            if (out_n !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL dead_time[%0d]: got out_n=%b, exp %b", i, out_n, exp_seq[i]);
            end
            if (i < 2) step();
        end
        n_cmp++;
        if ({active_idx, valid} !== {2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL dead_time_idx: got idx=%0d valid=%b, exp idx=3 valid=1", active_idx, valid);
        end
    endtask

    task automatic test_sel_return();
        sel = 2'd1;
        step();
        n_cmp++;
        if (out_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL return_blank: got out_n=%b, exp 1111", out_n);
        end
        sel = 2'd3;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b0111, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL return_reload: got out_n=%b idx=%0d valid=%b, exp out_n=0111 idx=3 valid=1",
                     out_n, active_idx, valid);
        end
    endtask

    task automatic test_disable_mid_blank();
        sel = 2'd0;
        step();  // now in BLANK
        en = 1'b0;
        step();
        n_cmp++;
        if ({out_n, valid} !== {4'b1111, 1'b0}) begin
            n_bad++;
            $display("FAIL disable_blank: got out_n=%b valid=%b, exp out_n=1111 valid=0", out_n, valid);
        end
        step();
        n_cmp++;
        if ({out_n, valid} !== {4'b1111, 1'b0}) begin
            n_bad++;
            $display("FAIL disable_hold: got out_n=%b valid=%b, exp out_n=1111 valid=0", out_n, valid);
        end
        en = 1'b1; mode = 1'b1; sel = 2'd2;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1110, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reenable_scan: got out_n=%b idx=%0d valid=%b, exp out_n=1110 idx=0 valid=1",
                     out_n, active_idx, valid);
        end
        en = 1'b0;
        step();
        n_cmp++;
        if ({out_n, valid} !== {4'b1111, 1'b0}) begin
            n_bad++;
            $display("FAIL disable_drive: got out_n=%b valid=%b, exp out_n=1111 valid=0", out_n, valid);
        end
    endtask

    task automatic test_scan();
        logic [3:0] e_out;
        logic [1:0] e_idx;
        logic       e_v;
        int         ch;
        en = 1'b0; mode = 1'b1; sens = 3'b111;
        step();
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c < 4) begin
                e_out = 4'b1110; e_idx = 2'd0; e_v = 1'b1;
            end else if ((c - 4) % 4 == 0) begin
                e_out = 4'b1111; e_idx = 2'(((c - 4) / 4) % 4); e_v = 1'b0;
            end else begin
                ch    = ((c - 4) / 4 + 1) % 4;
                e_out = 4'b1111;
                e_out[ch] = 1'b0;
                e_idx = 2'(ch); e_v = 1'b1;
            end
            n_cmp++;
            if ({out_n, active_idx, valid} !== {e_out, e_idx, e_v}) begin
                n_bad++;
                $display("FAIL scan[%0d]: got out_n=%b idx=%0d valid=%b, exp out_n=%b idx=%0d valid=%b",
                         c, out_n, active_idx, valid, e_out, e_idx, e_v);
            end
            n_cmp++;
            if ($countones(~out_n) > 1) begin
                n_bad++;
                $display("FAIL scan_onecold[%0d]: got out_n=%b, exp at most one low bit", c, out_n);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b0; mode = 1'b1; sens = 3'b010;
        step();
        en = 1'b1;
        for (int c = 0; c < 10; c++) step();  // edge 9 drives channel 2
        n_cmp++;
        if ({out_n, active_idx} !== {4'b1011, 2'd2}) begin
            n_bad++;
            $display("FAIL midscan_pre: got out_n=%b idx=%0d, exp out_n=1011 idx=2", out_n, active_idx);
        end
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1111, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL midscan_reset: got out_n=%b idx=%0d valid=%b, exp out_n=1111 idx=0 valid=0",
                     out_n, active_idx, valid);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1110, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL midscan_restart: got out_n=%b idx=%0d valid=%b, exp out_n=1110 idx=0 valid=1",
                     out_n, active_idx, valid);
        end
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1111, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL midscan_blank: got out_n=%b idx=%0d valid=%b, exp out_n=1111 idx=0 valid=0",
                     out_n, active_idx, valid);
        end
        step();
        n_cmp++;
        if ({out_n, active_idx, valid} !== {4'b1101, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL midscan_ch1: got out_n=%b idx=%0d valid=%b, exp out_n=1101 idx=1 valid=1",
                     out_n, active_idx, valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; sens = '0;
        test_reset();
        test_inhibit();
        test_dead_time();
        test_sel_return();
        test_disable_mid_blank();
        test_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
